// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, jump, relative branch, call/return via return-address stack.
// Latency: pc_out updates one cycle after the strobe edge; no backpressure, hold freezes all state.
module pc_seq_unit #(
  parameter int              ADDR_W    = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hold,
  input  logic                             jump,
  input  logic [ADDR_W-1:0]                jump_addr,
  input  logic                             branch,
  input  logic [ADDR_W-1:0]                branch_off,
  input  logic                             call,
  input  logic                             ret,
  output logic [ADDR_W-1:0]                pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ras_ovf,
  output logic                             ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH+1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int STK_N = 1 << IDX_W;

  logic [ADDR_W-1:0] stack [STK_N];

  // Only a clean 1 acts; X/Z on a strobe falls through as deasserted.
  logic do_hold, do_ret, do_call, do_jump, do_branch;
  assign do_hold   = (hold   === 1'b1);
  assign do_ret    = (ret    === 1'b1);
  assign do_call   = (call   === 1'b1);
  assign do_jump   = (jump   === 1'b1);
  assign do_branch = (branch === 1'b1);

  logic [ADDR_W-1:0] pc_inc;
  logic [CNT_W-1:0]  cnt_dec;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              push;

  assign pc_inc  = pc_out + ADDR_W'(1);
  assign cnt_dec = ras_count - CNT_W'(1);
  assign wr_idx  = ras_count[IDX_W-1:0];
  assign rd_idx  = cnt_dec[IDX_W-1:0];

  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  assign push = do_call & ~do_ret & ~do_hold & ~ras_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= RESET_VEC;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (do_hold) begin
      pc_out    <= pc_out;
    end else if (do_ret) begin
      if (!ras_empty) begin
        pc_out    <= stack[rd_idx];
        ras_count <= cnt_dec;
      end else begin
        pc_out  <= pc_inc;
        ras_unf <= 1'b1;
      end
    end else if (do_call) begin
      pc_out <= jump_addr;
      if (!ras_full) ras_count <= ras_count + CNT_W'(1);
      else           ras_ovf   <= 1'b1;
    end else if (do_jump) begin
      pc_out <= jump_addr;
    end else if (do_branch) begin
      // Offset is two's complement relative to the current PC; modular add covers both signs.
      pc_out <= pc_out + branch_off;
    end else begin
      pc_out <= pc_inc;
    end
  end

  // Stack contents need no reset; ras_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed-vector bench for pc_seq_unit with a queue-based scoreboard and decoupled monitor.
module tb_pc_seq_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold, jump, branch, call, ret;
  logic [7:0] jump_addr, branch_off;
  logic [7:0] pc_out;
  logic [2:0] ras_count;
  logic       ras_full, ras_empty, ras_ovf, ras_unf;

  pc_seq_unit #(.ADDR_W(8), .RAS_DEPTH(4), .RESET_VEC(8'h10)) dut (
    .clk(clk), .rst(rst), .hold(hold), .jump(jump), .jump_addr(jump_addr),
    .branch(branch), .branch_off(branch_off), .call(call), .ret(ret),
    .pc_out(pc_out), .ras_count(ras_count), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Monitor: samples shortly after each falling clock edge, and after a reset rising edge
  // so an asynchronous reset can be observed before any clock edge.
  always @(negedge clk or posedge rst) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      logic ef, ee;
      e  = exp_q.pop_front();
      ef = (e.cnt == 3'd4);
      ee = (e.cnt == 3'd0);
      n_vec++;
      if (pc_out !== e.pc || ras_count !== e.cnt || ras_full !== ef || ras_empty !== ee ||
          ras_ovf !== e.ovf || ras_unf !== e.unf) begin
        n_fail++;
        $display("FAIL %s: got pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                 e.name, pc_out, ras_count, ras_full, ras_empty, ras_ovf, ras_unf,
                 e.pc, e.cnt, ef, ee, e.ovf, e.unf);
      end
    end
  end

  task automatic expect_state(input string nm, input logic [7:0] pc, input logic [2:0] cnt,
                              input logic ovf, input logic unf);
    exp_t e;
    e.name = nm; e.pc = pc; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  // One clocked action: drive strobes, take the edge, queue the expected post-edge state.
  task automatic step(input string nm,
                      input logic h, input logic r, input logic c, input logic j,
                      input logic b, input logic [7:0] ja, input logic [7:0] bo,
                      input logic [7:0] pc, input logic [2:0] cnt,
                      input logic ovf, input logic unf);
    hold = h; ret = r; call = c; jump = j; branch = b; jump_addr = ja; branch_off = bo;
    @(posedge clk);
    #1;
    expect_state(nm, pc, cnt, ovf, unf);
    hold = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
    jump_addr = 8'h00; branch_off = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 8'h10, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    //   name          h  r  c  j  b  ja     bo     pc     cnt ovf unf
    step("inc1",       0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0);
    step("inc2",       0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0);
    step("inc3",       0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h13, 0, 0, 0);
    repeat (235) begin
      @(posedge clk);
      #1;
    end
    step("inc_ff",     0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
    step("inc_wrap",   0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    step("jump_20",    0, 0, 0, 1, 0, 8'h20, 8'h00, 8'h20, 0, 0, 0);
    step("hold_jump",  1, 0, 0, 1, 0, 8'h80, 8'h00, 8'h20, 0, 0, 0);
    step("jump_gt_br", 0, 0, 0, 1, 1, 8'h80, 8'h10, 8'h80, 0, 0, 0);
    step("hold_ret",   1, 1, 1, 0, 0, 8'h44, 8'h00, 8'h80, 0, 0, 0);

    step("jump_05",    0, 0, 0, 1, 0, 8'h05, 8'h00, 8'h05, 0, 0, 0);
    step("branch_m2",  0, 0, 0, 0, 1, 8'h00, 8'hFE, 8'h03, 0, 0, 0);
    step("jump_fe",    0, 0, 0, 1, 0, 8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    step("branch_wrp", 0, 0, 0, 0, 1, 8'h00, 8'h04, 8'h02, 0, 0, 0);
    step("jump_x",     0, 0, 0, 1'bx, 0, 8'hAA, 8'h00, 8'h03, 0, 0, 0);

    step("jump_10",    0, 0, 0, 1, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    step("call_40",    0, 0, 1, 0, 0, 8'h40, 8'h00, 8'h40, 1, 0, 0);
    step("inc_41",     0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41, 1, 0, 0);
    step("call_60",    0, 0, 1, 0, 0, 8'h60, 8'h00, 8'h60, 2, 0, 0);
    step("ret_42",     0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h42, 1, 0, 0);
    step("ret_11",     0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0);

    step("call_70",    0, 0, 1, 0, 0, 8'h70, 8'h00, 8'h70, 1, 0, 0);
    step("call_50",    0, 0, 1, 0, 0, 8'h50, 8'h00, 8'h50, 2, 0, 0);
    step("call_ret",   0, 1, 1, 0, 0, 8'h99, 8'h00, 8'h71, 1, 0, 0);
    step("ret_12",     0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0);

    step("fill1",      0, 0, 1, 0, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0);
    step("fill2",      0, 0, 1, 0, 0, 8'h25, 8'h00, 8'h25, 2, 0, 0);
    step("fill3",      0, 0, 1, 0, 0, 8'h30, 8'h00, 8'h30, 3, 0, 0);
    step("fill4",      0, 0, 1, 0, 0, 8'h32, 8'h00, 8'h32, 4, 0, 0);
    step("inc_33",     0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h33, 4, 0, 0);
    step("call_ovf",   0, 0, 1, 0, 0, 8'h90, 8'h00, 8'h90, 4, 1, 0);
    step("pop4",       0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h31, 3, 1, 0);
    step("pop3",       0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h26, 2, 1, 0);
    step("pop2",       0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h21, 1, 1, 0);
    step("pop1",       0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h13, 0, 1, 0);
    step("ret_unf",    0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h14, 0, 1, 1);
    step("sticky",     0, 0, 0, 1, 0, 8'h77, 8'h00, 8'h77, 0, 1, 1);

    // Reset asserted between clock edges must take effect before the next rising edge.
    @(negedge clk);
    #2;
    expect_state("async_rst", 8'h10, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst",   0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0);

    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer, the next generation of the core's 8-bit PC register. Holds the instruction address and advances it by increment, absolute jump, PC-relative branch, or subroutine call/return through an internal return-address stack (RAS). Sits between the decode/control unit, which drives the control strobes, and instruction memory, which consumes pc_out. Sticky stack-error flags are visible to the control unit.

Parameters:
ADDR_W, 8, PC and address width in bits (>=4)
RAS_DEPTH, 4, return-address stack entries (>=1, power of 2 not required)
RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
hold  input  1  freeze PC and stack this cycle
jump  input  1  load jump_addr
jump_addr  input  ADDR_W  absolute target for jump and call
branch  input  1  PC-relative branch
branch_off  input  ADDR_W  two's-complement branch offset
call  input  1  push return address, load jump_addr
ret  input  1  pop return address into PC
pc_out  output  ADDR_W  current PC (registered)
ras_count  output  clog2(RAS_DEPTH+1)  occupied stack entries
ras_full  output  1  ras_count == RAS_DEPTH
ras_empty  output  1  ras_count == 0
ras_ovf  output  1  sticky: call attempted while full
ras_unf  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (async, any time, including mid-call/ret):
  - pc_out = RESET_VEC; ras_count = 0; ras_ovf = ras_unf = 0.
  - Stack contents are don't-care.
  - First edge after rst deasserts applies normal next-PC rules.
- One action per rising edge, strict priority: hold > ret > call > jump > branch > increment. Lower-priority strobes asserted in the same cycle are ignored, with no side effects.
- hold: pc_out, stack, ras_count and flags all unchanged. Sticky flags are not set while hold is asserted.
- ret:
  - ras_count > 0: pc_out <= top entry; ras_count decrements.
  - ras_count == 0: pc_out <= pc_out + 1; ras_unf <= 1.
- call:
  - Return address pushed is pc_out + 1 (mod 2^ADDR_W).
  - ras_count < RAS_DEPTH: push the return address; ras_count increments; pc_out <= jump_addr.
  - Full: no push, existing entries preserved; pc_out <= jump_addr; ras_ovf <= 1.
- jump: pc_out <= jump_addr.
- branch: pc_out <= pc_out + branch_off, with branch_off read as signed. The offset is relative to the current PC, not PC+1.
- Increment: pc_out <= pc_out + 1.
- Arithmetic: all sums truncated to ADDR_W bits. Wrap-around at max address to 0, and below 0 to max, is legal and silent.
- Latency: the new pc_out is visible one cycle after the strobe edge. No combinational path from any input to any output.
- ras_full, ras_empty: combinational decodes of ras_count only.
- Sticky flags: cleared only by rst.
- Stack: LIFO, implemented as a register array plus pointer. A call at depth N followed by N rets returns the addresses in reverse push order.
- Control inputs are 1-bit. X/Z on a strobe is treated as deasserted, so only a clean 1 acts.

Test Plan:
- Reset/increment (ADDR_W=8, RESET_VEC=0x10): assert rst mid-run -> pc_out=0x10 immediately, without waiting for a clock edge. Release rst, 3 clocks -> 0x11, 0x12, 0x13. Run to 0xFF, 1 clock -> 0x00.
- Hold and priority: at pc=0x20, hold=1 with jump=1, jump_addr=0x80 -> pc stays 0x20. Next cycle drop hold, keep jump=1, branch=1 -> 0x80, branch ignored.
- Branch: pc=0x05, branch_off=0xFE (-2) -> 0x03. pc=0xFE, branch_off=0x04 -> 0x02 (wrap).
- Nested call/ret (RAS_DEPTH=4): call 0x40 at pc=0x10, then call 0x60 at pc=0x41 -> ras_count=2. First ret -> 0x42. Second ret -> 0x11, ras_empty=1.
- Overflow/underflow: 4 calls -> ras_full=1. 5th call at pc=0x33 with jump_addr=0x90 -> pc=0x90, ras_ovf=1, count stays 4, stack unchanged. Then 4 rets return the original 4 addresses. 5th ret at pc=p -> pc=p+1, ras_unf=1. Both flags stay high until rst.
- Simultaneous call+ret with count=2 -> ret wins: pc=top entry, count=1, no push.
